// File: rtl/async_fifo_rd_stream.sv
// async_fifo_rd_stream
// Read-domain front end of an asynchronous FIFO.
// - Brings the write-domain Gray write pointer into rclk with a 2-flop synchronizer.
// - Keeps the binary and Gray read pointers and the empty flag.
// - Issues reads to a synchronous-read dual-port RAM; rdata arrives one cycle
//   after ren.
// - Returned words sit in a 2-entry buffer and leave as a first-word-fall-through
//   valid/ready stream.
//
// Optional feature: define ASYNC_FIFO_RD_LEVEL_EN to build the registered
// occupancy (rlevel) and almost-empty (ralmost_empty) logic. Without it, rlevel
// is tied to 0 and ralmost_empty is tied to 1.
//
// Ports:
//   rclk, rrst_n   read clock; asynchronous active-low reset
//   wptr_gray      unsynchronized Gray write pointer from the write domain
//   rptr           registered Gray read pointer, to the write-domain synchronizer
//   raddr, ren     RAM read address and read enable
//   rdata          RAM read data, valid the cycle after ren
//   m_valid, m_data, m_ready   output stream
//   rempty         RAM storage empty as seen in rclk (output buffer not counted)
//   rlevel         synchronized RAM occupancy
//   ralmost_empty  rlevel <= AE_THRESH
module async_fifo_rd_stream #(
   parameter int DEPTH     = 16,
   parameter int WIDTH     = 8,
   parameter int AE_THRESH = 2
) (
   input  logic                       rclk,
   input  logic                       rrst_n,
   input  logic [$clog2(DEPTH):0]     wptr_gray,
   output logic [$clog2(DEPTH):0]     rptr,
   output logic [$clog2(DEPTH)-1:0]   raddr,
   output logic                       ren,
   input  logic [WIDTH-1:0]           rdata,
   output logic                       m_valid,
   output logic [WIDTH-1:0]           m_data,
   input  logic                       m_ready,
   output logic                       rempty,
   output logic [$clog2(DEPTH):0]     rlevel,
   output logic                       ralmost_empty
);

   localparam int AW = $clog2(DEPTH);

   if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("async_fifo_rd_stream: DEPTH must be a power of 2 and at least 4");
   end
   if ((AE_THRESH < 0) || (AE_THRESH > DEPTH)) begin : g_bad_thresh
      $error("async_fifo_rd_stream: AE_THRESH must lie in 0..DEPTH");
   end

   logic [AW:0]      rq1_wptr;
   logic [AW:0]      rq2_wptr;
   logic [AW:0]      rbin;
   logic [AW:0]      rbinnext;
   logic [AW:0]      rgraynext;
   logic             f;
   logic             pop;
   logic [1:0]       oc;
   logic [2:0]       oc_after;
   logic [WIDTH-1:0] buf0;
   logic [WIDTH-1:0] buf1;

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rq1_wptr <= '0;
         rq2_wptr <= '0;
      end else begin
         rq1_wptr <= wptr_gray;
         rq2_wptr <= rq1_wptr;
      end
   end

   // Occupancy the buffer will have after this edge, counting the word already
   // in flight from the RAM. A new read is only issued if that leaves room for
   // the word it will return, so the 2-entry buffer can never overflow.
   assign pop      = m_valid & m_ready;
   assign oc_after = {1'b0, oc} + {2'b00, f} - {2'b00, pop};
   assign ren      = !rempty && (oc_after < 3'd2);

   assign rbinnext  = rbin + {{AW{1'b0}}, ren};
   assign rgraynext = (rbinnext >> 1) ^ rbinnext;
   assign raddr     = rbin[AW-1:0];

   // rempty is computed from the post-increment pointer so it asserts on the
   // same edge as the last read, never allowing a read past the write pointer.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rbin   <= '0;
         rptr   <= '0;
         rempty <= 1'b1;
         f      <= 1'b0;
      end else begin
         rbin   <= rbinnext;
         rptr   <= rgraynext;
         rempty <= (rgraynext == rq2_wptr);
         f      <= ren;
      end
   end

   // buf0 is always the head. A pop shifts buf1 forward; a capture fills the
   // first slot left free after any pop in the same cycle.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         oc   <= 2'd0;
         buf0 <= '0;
         buf1 <= '0;
      end else begin
         oc <= oc_after[1:0];
         if (pop) begin
            if (f && (oc == 2'd1)) begin
               buf0 <= rdata;
            end else begin
               buf0 <= buf1;
            end
            if (f && (oc == 2'd2)) begin
               buf1 <= rdata;
            end
         end else if (f) begin
            if (oc == 2'd0) begin
               buf0 <= rdata;
            end else begin
               buf1 <= rdata;
            end
         end
      end
   end

   assign m_valid = (oc != 2'd0);
   assign m_data  = buf0;

`ifdef ASYNC_FIFO_RD_LEVEL_EN
   localparam logic [AW:0] AE_LIMIT = (AW + 1)'(AE_THRESH);

   function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
      logic [AW:0] b;
      b[AW] = g[AW];
      for (int i = AW - 1; i >= 0; i--) begin
         b[i] = b[i + 1] ^ g[i];
      end
      return b;
   endfunction

   logic [AW:0] rlevel_next;

   // Modulo 2^(AW+1) difference of the two pointers gives 0..DEPTH directly.
   assign rlevel_next = gray2bin(rq2_wptr) - rbin;

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rlevel        <= '0;
         ralmost_empty <= 1'b1;
      end else begin
         rlevel        <= rlevel_next;
         ralmost_empty <= (rlevel_next <= AE_LIMIT);
      end
   end
`else
   assign rlevel        = '0;
   assign ralmost_empty = 1'b1;
`endif

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// tb_async_fifo_rd_stream
// Self-checking bench for async_fifo_rd_stream. The bench plays the write
// domain (a RAM array plus a Gray write pointer) and the consumer, and keeps a
// queue of the words written so every word leaving the stream is compared in
// order. Honours ASYNC_FIFO_RD_LEVEL_EN for the level/almost-empty expectations.
module tb_async_fifo_rd_stream;

   localparam int DEPTH     = 16;
   localparam int WIDTH     = 8;
   localparam int AE_THRESH = 2;
   localparam int AW        = 4;

`ifdef ASYNC_FIFO_RD_LEVEL_EN
   localparam bit LEVEL_EN = 1'b1;
`else
   localparam bit LEVEL_EN = 1'b0;
`endif

   logic             rclk = 1'b0;
   logic             rrst_n = 1'b0;
   logic [AW:0]      wptr_gray = '0;
   logic [AW:0]      rptr;
   logic [AW-1:0]    raddr;
   logic             ren;
   logic [WIDTH-1:0] rdata = '0;
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   logic             m_ready = 1'b0;
   logic             rempty;
   logic [AW:0]      rlevel;
   logic             ralmost_empty;

   async_fifo_rd_stream #(
      .DEPTH(DEPTH),
      .WIDTH(WIDTH),
      .AE_THRESH(AE_THRESH)
   ) dut (
      .rclk(rclk),
      .rrst_n(rrst_n),
      .wptr_gray(wptr_gray),
      .rptr(rptr),
      .raddr(raddr),
      .ren(ren),
      .rdata(rdata),
      .m_valid(m_valid),
      .m_data(m_data),
      .m_ready(m_ready),
      .rempty(rempty),
      .rlevel(rlevel),
      .ralmost_empty(ralmost_empty)
   );

   always #5 rclk = ~rclk;

   // Synchronous-read RAM: data appears the cycle after ren.
   logic [WIDTH-1:0] mem [DEPTH];
   always @(posedge rclk) begin
      if (ren) rdata <= mem[raddr];
   end

   // Reads actually issued to the RAM.
   int renCount = 0;
   always @(posedge rclk) begin
      if (rrst_n && ren) renCount <= renCount + 1;
   end

   int               tests = 0;
   int               fails = 0;
   int               written = 0;
   int               popped = 0;
   logic [WIDTH-1:0] expq [$];
   bit               prevHold = 1'b0;
   logic [WIDTH-1:0] prevData = '0;
   logic [AW:0]      prevRptr = '0;
   bit               lastValid = 1'b0;

   function automatic logic [AW:0] gray(input int n);
      logic [AW:0] b;
      b = n[AW:0];
      return b ^ (b >> 1);
   endfunction

   function automatic int expLevel(input int lvl);
      return LEVEL_EN ? lvl : 0;
   endfunction

   function automatic logic expAe(input int lvl);
      return LEVEL_EN ? (lvl <= AE_THRESH) : 1'b1;
   endfunction

   // Words sitting in RAM (not counting the output buffer) once the DUT settles.
   function automatic int settledLevel();
      int outstanding;
      outstanding = written - popped;
      return outstanding - ((outstanding < 2) ? outstanding : 2);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic writeWord(input logic [WIDTH-1:0] d);
      mem[written % DEPTH] = d;
      expq.push_back(d);
      written++;
      wptr_gray = gray(written);
   endtask

   // One rclk cycle at the negedge: check stream rules, drive m_ready and any
   // writes, then account for the word (if any) accepted at the next posedge.
   task automatic applyStimulus(input bit ready, input int nwrites);
      @(negedge rclk);
      if (prevHold) begin
         checkOutput("hold_valid", {31'd0, m_valid}, 32'd1);
         checkOutput("hold_data", {24'd0, m_data}, {24'd0, prevData});
      end
      checkOutput("rptr_onebit", {31'd0, ($countones(rptr ^ prevRptr) <= 1)}, 32'd1);
      prevRptr = rptr;
      lastValid = m_valid;
      m_ready = ready;
      for (int i = 0; i < nwrites; i++) begin
         if ((written - popped) < DEPTH) writeWord(WIDTH'($urandom));
      end
      if (m_valid && m_ready) begin
         checkOutput("word_expected", {31'd0, (expq.size() != 0)}, 32'd1);
         if (expq.size() != 0) checkOutput("data_order", {24'd0, m_data}, {24'd0, expq.pop_front()});
         popped++;
      end
      prevHold = m_valid && !m_ready;
      prevData = m_data;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (((expq.size() != 0) || m_valid) && (guard < 200)) begin
         applyStimulus(1'b1, 0);
         guard++;
      end
      checkOutput("drain_timeout", {31'd0, (guard < 200)}, 32'd1);
      repeat (4) applyStimulus(1'b1, 0);
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_rempty"}, {31'd0, rempty}, 32'd1);
      checkOutput({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
      checkOutput({tag, "_ren"}, {31'd0, ren}, 32'd0);
      checkOutput({tag, "_rptr"}, {27'd0, rptr}, {27'd0, gray(written)});
      checkOutput({tag, "_raddr"}, {28'd0, raddr}, 32'(written % DEPTH));
      checkOutput({tag, "_rlevel"}, {27'd0, rlevel}, 32'd0);
      checkOutput({tag, "_ae"}, {31'd0, ralmost_empty}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: observed no finish expected finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int readBase;
      int target;
      int guard;
      int n;
      int run;
      bit done;

      for (int i = 0; i < DEPTH; i++) mem[i] = '0;

      // Reset state, during and after reset.
      repeat (3) @(negedge rclk);
      checkOutput("rst_rempty", {31'd0, rempty}, 32'd1);
      checkOutput("rst_m_valid", {31'd0, m_valid}, 32'd0);
      checkOutput("rst_m_data", {24'd0, m_data}, 32'd0);
      checkOutput("rst_rptr", {27'd0, rptr}, 32'd0);
      checkOutput("rst_ae", {31'd0, ralmost_empty}, 32'd1);
      rrst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         applyStimulus(1'b0, 0);
         checkIdle("reset_idle");
      end

      // Single write: m_valid rises at the 5th rclk edge after wptr advances.
      writeWord(8'hA5);
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(1'b0, 0);
         checkOutput("latency_valid", {31'd0, m_valid}, (k == 5) ? 32'd1 : 32'd0);
      end
      checkOutput("latency_data", {24'd0, m_data}, 32'hA5);
      drain();
      checkIdle("single");

      // Burst of 16 words with m_ready high: 16 consecutive valid cycles.
      for (int i = 0; i < 16; i++) writeWord(WIDTH'(i));
      run = 0;
      done = 1'b0;
      guard = 0;
      while (!done && (guard < 60)) begin
         applyStimulus(1'b1, 0);
         if (lastValid) run++;
         else if (run > 0) done = 1'b1;
         guard++;
      end
      checkOutput("burst_run", 32'(run), 32'd16);
      drain();
      checkIdle("burst");

      // Level / almost-empty: 5 written, 2 read into the buffer.
      readBase = renCount;
      for (int i = 0; i < 5; i++) writeWord(WIDTH'($urandom));
      repeat (15) applyStimulus(1'b0, 0);
      checkOutput("lvl_reads", 32'(renCount - readBase), 32'd2);
      checkOutput("lvl_rlevel", {27'd0, rlevel}, 32'(expLevel(settledLevel())));
      checkOutput("lvl_ae", {31'd0, ralmost_empty}, {31'd0, expAe(settledLevel())});
      applyStimulus(1'b1, 0);
      repeat (6) applyStimulus(1'b0, 0);
      checkOutput("lvl_reads2", 32'(renCount - readBase), 32'd3);
      checkOutput("lvl_rlevel2", {27'd0, rlevel}, 32'(expLevel(settledLevel())));
      checkOutput("lvl_ae2", {31'd0, ralmost_empty}, {31'd0, expAe(settledLevel())});
      drain();
      checkIdle("level");

      // Backpressure: 8 words, m_ready low for 20 cycles -> only 2 reads.
      readBase = renCount;
      for (int i = 0; i < 8; i++) writeWord(WIDTH'($urandom));
      repeat (20) applyStimulus(1'b0, 0);
      checkOutput("bp_reads", 32'(renCount - readBase), 32'd2);
      checkOutput("bp_valid", {31'd0, m_valid}, 32'd1);
      checkOutput("bp_head", {24'd0, m_data}, {24'd0, expq[0]});
      drain();
      checkOutput("bp_all_popped", 32'(popped), 32'(written));
      checkIdle("backpressure");

      // Wrap: 3 passes of 16 words with random write rate and m_ready.
      target = written + 48;
      guard = 0;
      while ((popped < target) && (guard < 3000)) begin
         n = (written < target) ? $urandom_range(0, 2) : 0;
         if (n > target - written) n = target - written;
         applyStimulus($urandom_range(0, 3) != 0, n);
         guard++;
      end
      checkOutput("wrap_timeout", {31'd0, (guard < 3000)}, 32'd1);
      drain();
      checkIdle("wrap");

      // Heavier random backpressure.
      target = written + 40;
      guard = 0;
      while ((popped < target) && (guard < 3000)) begin
         n = (written < target) ? $urandom_range(0, 3) : 0;
         if (n > target - written) n = target - written;
         applyStimulus($urandom_range(0, 1) != 0, n);
         guard++;
      end
      checkOutput("random_timeout", {31'd0, (guard < 3000)}, 32'd1);
      drain();
      checkIdle("random");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
